// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// funct3 codes, FSM states and fault causes.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_RANGE    = 2'b10,
        CAUSE_ILLEGAL  = 2'b11
    } lsu_cause_e;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering: store replication/enables or load extract/extend.
// Used once per direction; store_i selects which data path is produced.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    assign byte_sel = data_i[{off_i, 3'b000} +: 8];
    assign half_sel = data_i[{off_i[1], 4'b0000} +: 16];
    assign sext     = ~funct3_i[2];

    always_comb begin
        be_o   = 4'b1111;
        data_o = data_i;
        case (funct3_i[1:0])
            2'b00:   be_o = 4'b0001 << off_i;
            2'b01:   be_o = off_i[1] ? 4'b1100 : 4'b0011;
            default: be_o = 4'b1111;
        endcase
        if (store_i) begin
            case (funct3_i[1:0])
                2'b00:   data_o = {4{data_i[7:0]}};
                2'b01:   data_o = {2{data_i[15:0]}};
                default: data_o = data_i;
            endcase
        end else begin
            case (funct3_i[1:0])
                2'b00:   data_o = {{24{byte_sel[7] & sext}}, byte_sel};
                2'b01:   data_o = {{16{half_sel[15] & sext}}, half_sel};
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: checks the access, issues it over req/ready and
// stalls the core until the memory completes it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE         = 32'h1001_0000,
    parameter int          DATA_MEMORY_DEPTH = 128,
    localparam int         AW                = $clog2(DATA_MEMORY_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Mem_Read_i,
    input  logic          Mem_Write_i,
    input  logic [2:0]    funct3_i,
    input  logic [31:0]   Address_i,
    input  logic [31:0]   Write_Data_i,
    output logic          Stall_o,
    output logic [31:0]   Load_Data_o,
    output logic          Load_Valid_o,
    output logic          Fault_o,
    output logic [1:0]    Fault_Cause_o,
    output logic          Mem_Req_o,
    output logic          Mem_We_o,
    output logic [AW-1:0] Mem_Word_Addr_o,
    output logic [3:0]    Mem_Byte_En_o,
    output logic [31:0]   Mem_Wdata_o,
    input  logic          Mem_Ready_i,
    input  logic [31:0]   Mem_Rdata_i
);

    localparam logic [31:0] MEM_BYTES = 32'(4 * DATA_MEMORY_DEPTH);

    lsu_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_q, req_d;
    logic [2:0]    fn_q, fn_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   ldata_q, ldata_d;
    logic          lvalid_q, lvalid_d;

    logic [31:0] off;
    logic        access, ill, rng, mis;
    logic [3:0]  st_be, ld_be_unused;
    logic [31:0] st_data, ld_data;
    lsu_cause_e  cause;

    assign off    = Address_i - ADDR_BASE;
    assign access = Mem_Read_i | Mem_Write_i;
    assign rng    = (Address_i < ADDR_BASE) || (off >= MEM_BYTES);
    assign mis    = ((funct3_i[1:0] == 2'b01) && off[0]) ||
                    ((funct3_i[1:0] == 2'b10) && (off[1:0] != 2'b00));
    assign ill    = (Mem_Read_i && Mem_Write_i) ||
                    (Mem_Read_i && (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11)) ||
                    (Mem_Write_i && (funct3_i >= 3'b011));

    always_comb begin
        cause = CAUSE_NONE;
        if (ill)      cause = CAUSE_ILLEGAL;
        else if (rng) cause = CAUSE_RANGE;
        else if (mis) cause = CAUSE_MISALIGN;
    end

    lsu_data_align u_store_align (
        .store_i  (1'b1),
        .funct3_i (funct3_i),
        .off_i    (off[1:0]),
        .data_i   (Write_Data_i),
        .be_o     (st_be),
        .data_o   (st_data)
    );

    lsu_data_align u_load_align (
        .store_i  (1'b0),
        .funct3_i (fn_q),
        .off_i    (off_q),
        .data_i   (Mem_Rdata_i),
        .be_o     (ld_be_unused),
        .data_o   (ld_data)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        req_d         = req_q;
        fn_d          = fn_q;
        off_d         = off_q;
        ldata_d       = ldata_q;
        lvalid_d      = 1'b0;
        Stall_o       = 1'b0;
        Fault_o       = 1'b0;
        Fault_Cause_o = CAUSE_NONE;
        case (state_q)
            IDLE: begin
                if (access && cause != CAUSE_NONE) begin
                    Fault_o       = 1'b1;
                    Fault_Cause_o = cause;
                end else if (access) begin
                    Stall_o = 1'b1;
                    addr_d  = off[AW+1:2];
                    we_d    = Mem_Write_i;
                    be_d    = st_be;
                    wdata_d = st_data;
                    fn_d    = funct3_i;
                    off_d   = off[1:0];
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                Stall_o = 1'b1;
                if (Mem_Ready_i) begin
                    req_d    = 1'b0;
                    lvalid_d = ~we_q;
                    if (!we_q) ldata_d = ld_data;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            fn_q     <= '0;
            off_q    <= '0;
            ldata_q  <= '0;
            lvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            fn_q     <= fn_d;
            off_q    <= off_d;
            ldata_q  <= ldata_d;
            lvalid_q <= lvalid_d;
        end
    end

    // A rejected access must read as zero; otherwise the last load is held.
    assign Load_Data_o     = Fault_o ? 32'h0 : ldata_q;
    assign Load_Valid_o    = lvalid_q;
    assign Mem_Req_o       = req_q;
    assign Mem_We_o        = we_q;
    assign Mem_Word_Addr_o = addr_q;
    assign Mem_Byte_En_o   = be_q;
    assign Mem_Wdata_o     = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model.
// The bench also plays the variable-latency memory.
module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        Mem_Read_i, Mem_Write_i;
    logic [2:0]  funct3_i;
    logic [31:0] Address_i, Write_Data_i;
    logic        Stall_o, Load_Valid_o, Fault_o;
    logic [31:0] Load_Data_o;
    logic [1:0]  Fault_Cause_o;
    logic        Mem_Req_o, Mem_We_o;
    logic [6:0]  Mem_Word_Addr_o;
    logic [3:0]  Mem_Byte_En_o;
    logic [31:0] Mem_Wdata_o;
    logic        Mem_Ready_i;
    logic [31:0] Mem_Rdata_i;

    logic [31:0] tbmem   [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_ld;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .Mem_Read_i      (Mem_Read_i),
        .Mem_Write_i     (Mem_Write_i),
        .funct3_i        (funct3_i),
        .Address_i       (Address_i),
        .Write_Data_i    (Write_Data_i),
        .Stall_o         (Stall_o),
        .Load_Data_o     (Load_Data_o),
        .Load_Valid_o    (Load_Valid_o),
        .Fault_o         (Fault_o),
        .Fault_Cause_o   (Fault_Cause_o),
        .Mem_Req_o       (Mem_Req_o),
        .Mem_We_o        (Mem_We_o),
        .Mem_Word_Addr_o (Mem_Word_Addr_o),
        .Mem_Byte_En_o   (Mem_Byte_En_o),
        .Mem_Wdata_o     (Mem_Wdata_o),
        .Mem_Ready_i     (Mem_Ready_i),
        .Mem_Rdata_i     (Mem_Rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_cause(input bit rd, input bit wr,
                                             input logic [2:0] f3,
                                             input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        if ((rd && wr) || (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
            (wr && f3 > 3'd2))
            return 2'd3;
        if (a < BASE || a >= BASE + 4 * DEPTH) return 2'd2;
        if (a % sz != 0) return 2'd1;
        return 2'd0;
    endfunction

    task automatic idle_inputs();
        Mem_Read_i   = 1'b0;
        Mem_Write_i  = 1'b0;
        funct3_i     = 3'd0;
        Address_i    = 32'h0;
        Write_Data_i = 32'h0;
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        tbmem[idx]   = v;
        ref_mem[idx] = v;
    endtask

    // Entered just after a rising edge with the DUT in IDLE.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int waits);
        logic [1:0]  ec;
        logic [31:0] idx, w, v, mask, ebe, ewd;
        int          lane, reqcnt, stall_cnt;
        Mem_Read_i   = rd;
        Mem_Write_i  = wr;
        funct3_i     = f3;
        Address_i    = a;
        Write_Data_i = wd;
        #1;
        ec = exp_cause(rd, wr, f3, a);
        if (ec != 2'd0) begin
            chk("fault", Fault_o, 1);
            chk("cause", Fault_Cause_o, ec);
            chk("flt_stall", Stall_o, 0);
            chk("flt_ldata", Load_Data_o, 0);
            @(posedge clk); #1;
            chk("flt_req", Mem_Req_o, 0);
            idle_inputs();
            #1;
            chk("flt_hold", Load_Data_o, last_ld);
            return;
        end
        idx  = (a - BASE) >> 2;
        lane = int'(a[1:0]);
        w    = ref_mem[idx];
        v    = w;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * lane)) & 32'hFF;
                if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (8 * lane)) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        ebe  = ((f3 == 3'd0) ? 32'd1 : (f3 == 3'd1) ? 32'd3 : 32'd15) << lane;
        ewd  = (f3 == 3'd0) ? (wd & 32'hFF) * 32'h0101_0101 :
               (f3 == 3'd1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        if (wr) begin
            mask = mask << (8 * lane);
            ref_mem[idx] = (w & ~mask) | ((wd << (8 * lane)) & mask);
        end
        chk("c0_stall", Stall_o, 1);
        chk("c0_fault", Fault_o, 0);
        chk("c0_req", Mem_Req_o, 0);
        stall_cnt = 1;
        reqcnt    = 0;
        @(posedge clk); #1;
        while (Mem_Req_o === 1'b1 && reqcnt < 40) begin
            reqcnt++;
            if (Stall_o) stall_cnt++;
            chk("waddr", {25'd0, Mem_Word_Addr_o}, idx);
            chk("we", Mem_We_o, wr);
            if (wr) begin
                chk("byte_en", {28'd0, Mem_Byte_En_o}, ebe);
                chk("wdata", Mem_Wdata_o, ewd);
            end
            if (reqcnt == waits + 1) begin
                Mem_Ready_i = 1'b1;
                Mem_Rdata_i = tbmem[Mem_Word_Addr_o];
                if (Mem_We_o)
                    for (int i = 0; i < 4; i++)
                        if (Mem_Byte_En_o[i])
                            tbmem[Mem_Word_Addr_o][8*i +: 8] = Mem_Wdata_o[8*i +: 8];
            end else begin
                Mem_Ready_i = 1'b0;
                Mem_Rdata_i = $urandom;
            end
            @(posedge clk); #1;
            Mem_Ready_i = 1'b0;
            Mem_Rdata_i = $urandom;
        end
        chk("req_cycles", reqcnt, waits + 1);
        chk("stall_cycles", stall_cnt, waits + 2);
        chk("done_stall", Stall_o, 0);
        chk("lvalid", Load_Valid_o, rd);
        if (rd) last_ld = v;
        chk("ldata", Load_Data_o, last_ld);
        if (wr) chk("memword", tbmem[idx], ref_mem[idx]);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("lvalid_clr", Load_Valid_o, 0);
        chk("ldata_hold", Load_Data_o, last_ld);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bit          rd, wr;
        int          r, sz;
        logic [2:0]  f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        last_ld     = 32'h0;
        reset       = 1'b1;
        Mem_Ready_i = 1'b0;
        Mem_Rdata_i = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", Stall_o, 0);
        chk("rst_req", Mem_Req_o, 0);
        chk("rst_lvalid", Load_Valid_o, 0);
        chk("rst_ldata", Load_Data_o, 0);
        chk("rst_fault", Fault_o, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(0, 1, 3'd2, 32'h1001_0004, 32'hDEAD_BEEF, 0);
        poke(1, 32'h80FF_0000);
        do_op(1, 0, 3'd0, 32'h1001_0007, 32'h0, 0);
        chk("lb_sext", last_ld, 32'hFFFF_FF80);
        do_op(1, 0, 3'd4, 32'h1001_0007, 32'h0, 1);
        chk("lbu_zext", last_ld, 32'h0000_0080);
        do_op(0, 1, 3'd1, 32'h1001_0002, 32'h1234_ABCD, 0);
        do_op(1, 0, 3'd2, 32'h1001_0006, 32'h0, 0);
        do_op(1, 0, 3'd2, 32'h1000_FFFC, 32'h0, 0);
        do_op(1, 0, 3'd7, 32'h1001_0000, 32'h0, 0);
        do_op(1, 1, 3'd2, 32'h1001_0000, 32'h0, 0);
        do_op(1, 0, 3'd2, 32'h1001_0010, 32'h0, 3);
        do_op(1, 0, 3'd2, 32'h1001_01FC, 32'h0, 0);
        do_op(0, 1, 3'd0, 32'h1001_0200, 32'h0, 0);

        Mem_Read_i = 1'b1;
        funct3_i   = 3'd2;
        Address_i  = 32'h1001_0020;
        @(posedge clk); #1;
        chk("rstreq_pre", Mem_Req_o, 1);
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk("rstreq_req", Mem_Req_o, 0);
        chk("rstreq_stall", Stall_o, 0);
        chk("rstreq_ldata", Load_Data_o, 0);
        last_ld = 32'h0;
        reset = 1'b0;
        do_op(1, 0, 3'd2, 32'h1001_0020, 32'h0, 1);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 19);
            f3 = f3_tab[$urandom_range(0, (r == 0) ? 7 : 5)];
            rd = $urandom_range(0, 1);
            wr = !rd || (r == 1);
            if (wr && !rd && f3[2] && r != 2) f3 = {1'b0, f3[1:0]};
            sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            a  = BASE + ($urandom_range(0, DEPTH - 1) << 2);
            a  = a + ($urandom_range(0, 3) & ~(sz - 1));
            if (r == 3) a = BASE + $urandom_range(0, 4 * DEPTH - 1);
            if (r == 4) a = BASE - $urandom_range(1, 64);
            if (r == 5) a = BASE + 4 * DEPTH + $urandom_range(0, 64);
            if (r == 6) a = $urandom;
            do_op(rd, wr, f3, a, $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
